branch_tag_scheduler: RTL and testbench

//  Allocates branch checkpoint tags to the branches in each 4-wide dispatch group.

---
 rtl/branch_tag_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_branch_tag_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_scheduler.sv
// Branch checkpoint tag scheduler.
// Hands out checkpoint tags to the branches of each 4-wide dispatch group,
// owns {rob_idx, pos} per in-flight branch, frees tags on commit and
// sequences mispredict recovery as a one-cycle flush followed by a drain stall.
//
//   state | meaning
//   IDLE  | normal dispatch; mispredict requests are looked up and accepted
//   FLUSH | flush pulse out; squash of the mispredicted and younger entries
//   DRAIN | dispatch stalled for DRAIN_CYCLES cycles, then back to IDLE
module branch_tag_scheduler #(
    parameter int NUM_TAGS     = 4,
    parameter int TAG_W        = 2,
    parameter int IDX_W        = 6,
    parameter int POS_W        = 6,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 grp_vld_i,
    input  logic [3:0]           grp_br_i,
    input  logic [IDX_W-1:0]     nxt_indx_i,
    input  logic [POS_W-1:0]     curr_pos_i,
    input  logic [3:0]           pr_need_inst_i,
    output logic                 grp_ack_o,
    output logic [4*TAG_W-1:0]   slot_tag_o,
    input  logic                 cmt_brch_i,
    input  logic [IDX_W-1:0]     cmt_brch_indx_i,
    input  logic [IDX_W-1:0]     rob_head_i,
    input  logic                 mis_pred_i,
    input  logic [IDX_W-1:0]     brch_mis_indx_i,
    output logic                 mis_ack_o,
    output logic                 mis_err_o,
    output logic                 flush_o,
    output logic [POS_W-1:0]     flush_pos_o,
    output logic [TAG_W-1:0]     flush_tag_o,
    output logic [TAG_W:0]       free_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int CMP_W = TAG_W + 3;
    localparam logic [TAG_W:0] FREE_ALL  = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0] FREE_ONE  = (TAG_W+1)'(1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);

    logic [NUM_TAGS-1:0] vld_q, vld_d;
    logic [IDX_W-1:0]    idx_q [NUM_TAGS];
    logic [IDX_W-1:0]    idx_d [NUM_TAGS];
    logic [POS_W-1:0]    pos_q [NUM_TAGS];
    logic [POS_W-1:0]    pos_d [NUM_TAGS];
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic [TAG_W-1:0]    mis_tag_q, mis_tag_d;
    logic [POS_W-1:0]    mis_pos_q, mis_pos_d;
    logic [TAG_W:0]      free_cnt_q, free_cnt_d;

    logic [IDX_W-1:0]    slot_idx [4];
    logic [POS_W-1:0]    slot_pos [4];
    logic [TAG_W-1:0]    slot_tag [4];
    logic [CMP_W-1:0]    br_cnt;
    logic                is_idle;
    logic                grp_ack;
    logic                mis_hit;
    logic [TAG_W-1:0]    mis_hit_tag;
    logic [NUM_TAGS-1:0] squash;

    assign is_idle = (state_q == ST_IDLE);

    // Per-slot ROB index and rename pointer position derived from slot 0.
    always_comb begin : slot_calc
        logic [POS_W-1:0] acc;
        acc = curr_pos_i;
        for (int k = 0; k < 4; k++) begin
            slot_idx[k] = nxt_indx_i + IDX_W'(k);
            slot_pos[k] = acc;
            acc         = acc + POS_W'(pr_need_inst_i[k]);
        end
    end

    // Branch count of the group and the all-or-nothing accept decision.
    always_comb begin
        br_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            br_cnt = br_cnt + CMP_W'(grp_br_i[k]);
        end
        grp_ack = grp_vld_i & is_idle & ~mis_pred_i & (br_cnt <= CMP_W'(free_cnt_q));
    end

    // Branch slots take the lowest free tags in ascending slot order.
    always_comb begin : tag_pick
        logic [NUM_TAGS-1:0] taken;
        logic                found;
        taken = vld_q;
        for (int k = 0; k < 4; k++) begin
            slot_tag[k] = '0;
            found       = 1'b0;
            if (grp_br_i[k]) begin
                for (int t = 0; t < NUM_TAGS; t++) begin
                    if (!found && !taken[t]) begin
                        slot_tag[k] = TAG_W'(t);
                        taken[t]    = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    // Mispredict lookup; on duplicate indices the lowest tag wins.
    always_comb begin
        mis_hit     = 1'b0;
        mis_hit_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (vld_q[t] && (idx_q[t] == brch_mis_indx_i)) begin
                mis_hit     = 1'b1;
                mis_hit_tag = TAG_W'(t);
            end
        end
    end

    // Entries killed by the flush: the mispredicted one plus anything younger.
    always_comb begin : squash_calc
        logic [IDX_W-1:0] dist_m;
        logic [IDX_W-1:0] dist_e;
        dist_m = idx_q[mis_tag_q] - rob_head_i;
        for (int t = 0; t < NUM_TAGS; t++) begin
            dist_e    = idx_q[t] - rob_head_i;
            squash[t] = (TAG_W'(t) == mis_tag_q) || (dist_e > dist_m);
        end
    end

    // Next-state: commit, allocation, FSM sequencing and free count.
    always_comb begin
        vld_d     = vld_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        state_d   = state_q;
        drain_d   = drain_q;
        mis_tag_d = mis_tag_q;
        mis_pos_d = mis_pos_q;

        if (cmt_brch_i) begin
            for (int t = 0; t < NUM_TAGS; t++) begin
                if (vld_q[t] && (idx_q[t] == cmt_brch_indx_i)) begin
                    vld_d[t] = 1'b0;
                end
            end
        end

        if (grp_ack) begin
            for (int k = 0; k < 4; k++) begin
                if (grp_br_i[k]) begin
                    vld_d[slot_tag[k]] = 1'b1;
                    idx_d[slot_tag[k]] = slot_idx[k];
                    pos_d[slot_tag[k]] = slot_pos[k];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (mis_pred_i && mis_hit) begin
                    mis_tag_d = mis_hit_tag;
                    mis_pos_d = pos_q[mis_hit_tag];
                    state_d   = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                vld_d   = vld_d & ~squash;
                drain_d = DRAIN_LD;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        free_cnt_d = FREE_ALL;
        for (int t = 0; t < NUM_TAGS; t++) begin
            if (vld_d[t]) begin
                free_cnt_d = free_cnt_d - FREE_ONE;
            end
        end
    end

    // State and table registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                idx_q[t] <= '0;
                pos_q[t] <= '0;
            end
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            mis_tag_q  <= '0;
            mis_pos_q  <= '0;
            free_cnt_q <= FREE_ALL;
        end else begin
            vld_q      <= vld_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            state_q    <= state_d;
            drain_q    <= drain_d;
            mis_tag_q  <= mis_tag_d;
            mis_pos_q  <= mis_pos_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    // Output drive; slot tags and flush payload are zero when not valid.
    always_comb begin
        grp_ack_o  = grp_ack;
        slot_tag_o = '0;
        for (int k = 0; k < 4; k++) begin
            if (grp_ack && grp_br_i[k]) begin
                slot_tag_o[k*TAG_W +: TAG_W] = slot_tag[k];
            end
        end
        mis_ack_o   = is_idle & mis_pred_i;
        mis_err_o   = is_idle & mis_pred_i & ~mis_hit;
        flush_o     = (state_q == ST_FLUSH);
        flush_pos_o = flush_o ? mis_pos_q : '0;
        flush_tag_o = flush_o ? mis_tag_q : '0;
        free_cnt_o  = free_cnt_q;
    end

endmodule

// File: tb/tb_branch_tag_scheduler.sv
// Self-checking bench for branch_tag_scheduler: directed scenarios followed by
// random traffic, all compared against a behavioural model of the tag table.
module tb_branch_tag_scheduler;

    logic       clk, rst;
    logic       grp_vld;
    logic [3:0] grp_br;
    logic [5:0] nxt_indx, curr_pos;
    logic [3:0] pr_need_inst;
    logic       grp_ack;
    logic [7:0] slot_tag;
    logic       cmt_brch;
    logic [5:0] cmt_brch_indx, rob_head;
    logic       mis_pred;
    logic [5:0] brch_mis_indx;
    logic       mis_ack, mis_err, flush;
    logic [5:0] flush_pos;
    logic [1:0] flush_tag;
    logic [2:0] free_cnt;

    branch_tag_scheduler dut (
        .clk_i(clk), .rst_i(rst),
        .grp_vld_i(grp_vld), .grp_br_i(grp_br), .nxt_indx_i(nxt_indx),
        .curr_pos_i(curr_pos), .pr_need_inst_i(pr_need_inst),
        .grp_ack_o(grp_ack), .slot_tag_o(slot_tag),
        .cmt_brch_i(cmt_brch), .cmt_brch_indx_i(cmt_brch_indx), .rob_head_i(rob_head),
        .mis_pred_i(mis_pred), .brch_mis_indx_i(brch_mis_indx),
        .mis_ack_o(mis_ack), .mis_err_o(mis_err), .flush_o(flush),
        .flush_pos_o(flush_pos), .flush_tag_o(flush_tag), .free_cnt_o(free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // behavioural model: table of in-flight branches plus recovery progress
    bit m_vld [4];
    int m_idx [4];
    int m_pos [4];
    bit m_flush;
    int m_drain;
    int m_ftag, m_fpos, m_fidx;
    bit last_ack, last_mack;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int t = 0; t < 4; t++) begin
            m_vld[t] = 0; m_idx[t] = 0; m_pos[t] = 0;
        end
        m_flush = 0; m_drain = 0; last_ack = 0; last_mack = 0;
    endtask

    task automatic idle_inputs();
        grp_vld = 0; grp_br = 0; nxt_indx = 0; curr_pos = 0; pr_need_inst = 0;
        cmt_brch = 0; cmt_brch_indx = 0; rob_head = 0; mis_pred = 0; brch_mis_indx = 0;
    endtask

    // Assert reset wherever we are (asynchronously), check, release at a negedge.
    task automatic hard_reset();
        idle_inputs();
        rst = 1;
        clear_model();
        #1;
        chk("rst_flush", flush, 0);
        chk("rst_free", free_cnt, 4);
        chk("rst_ack", grp_ack, 0);
        chk("rst_mack", mis_ack, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Check all outputs against the model for the inputs now applied,
    // advance the model, and move to the next negedge.
    task automatic cyc();
        int  nfree, nbr, htag, dm, t;
        bit  idle, ack;
        int  tags [4];
        int  q [$];
        #1;
        nfree = 0;
        for (int i = 0; i < 4; i++) if (!m_vld[i]) begin nfree++; q.push_back(i); end
        idle = !m_flush && (m_drain == 0);
        nbr  = $countones(grp_br);
        ack  = grp_vld && idle && !mis_pred && (nbr <= nfree);
        for (int k = 0; k < 4; k++) begin
            tags[k] = 0;
            if (ack && grp_br[k] && q.size() > 0) tags[k] = q.pop_front();
        end
        htag = -1;
        for (int i = 0; i < 4; i++)
            if (htag < 0 && m_vld[i] && m_idx[i] == int'(brch_mis_indx)) htag = i;

        chk("grp_ack", grp_ack, ack);
        if (ack)
            for (int k = 0; k < 4; k++)
                if (grp_br[k]) chk($sformatf("slot_tag%0d", k), slot_tag[k*2 +: 2], tags[k]);
        chk("mis_ack", mis_ack, idle && mis_pred);
        chk("mis_err", mis_err, idle && mis_pred && htag < 0);
        chk("flush", flush, m_flush);
        if (m_flush) begin
            chk("flush_pos", flush_pos, m_fpos);
            chk("flush_tag", flush_tag, m_ftag);
        end
        chk("free_cnt", free_cnt, nfree);

        last_ack  = ack;
        last_mack = idle && mis_pred;
        if (cmt_brch)
            for (int i = 0; i < 4; i++)
                if (m_vld[i] && m_idx[i] == int'(cmt_brch_indx)) m_vld[i] = 0;
        if (ack)
            for (int k = 0; k < 4; k++)
                if (grp_br[k]) begin
                    t = tags[k];
                    m_vld[t] = 1;
                    m_idx[t] = (int'(nxt_indx) + k) & 63;
                    m_pos[t] = (int'(curr_pos) + $countones(int'(pr_need_inst) & ((1 << k) - 1))) & 63;
                end
        if (m_flush) begin
            dm = (m_fidx - int'(rob_head)) & 63;
            for (int i = 0; i < 4; i++)
                if (i == m_ftag || ((m_idx[i] - int'(rob_head)) & 63) > dm) m_vld[i] = 0;
            m_flush = 0;
            m_drain = 3;
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (mis_pred && htag >= 0) begin
            m_flush = 1; m_ftag = htag; m_fpos = m_pos[htag]; m_fidx = m_idx[htag];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int rp;
        int vq [$];
        rst = 1;
        idle_inputs();
        clear_model();
        @(negedge clk);
        hard_reset();

        // first group: two branches, tags 0 and 1
        grp_vld = 1; grp_br = 4'b1010; nxt_indx = 10; curr_pos = 5; pr_need_inst = 4'b0111;
        rob_head = 10;
        #1;
        chk("t1_ack", grp_ack, 1);
        chk("t1_slot1", slot_tag[3:2], 0);
        chk("t1_slot3", slot_tag[7:6], 1);
        cyc();
        grp_vld = 0;
        #1 chk("t1_free", free_cnt, 2);
        mis_pred = 1; brch_mis_indx = 13;
        cyc();
        mis_pred = 0;
        #1;
        chk("t1_flush", flush, 1);
        chk("t1_fpos13", flush_pos, 8);
        chk("t1_ftag13", flush_tag, 1);
        cyc();
        grp_vld = 1; grp_br = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t1_drain_ack", grp_ack, 0);
            cyc();
        end
        #1 chk("t1_idle_ack", grp_ack, 1);
        cyc();
        grp_vld = 0; mis_pred = 1; brch_mis_indx = 11;
        cyc();
        mis_pred = 0;
        #1 chk("t1_fpos11", flush_pos, 6);
        cyc();
        repeat (3) cyc();

        // full-table refusal released by a commit
        hard_reset();
        grp_vld = 1; grp_br = 4'b0111; nxt_indx = 20; curr_pos = 0;
        cyc();
        grp_br = 4'b0011; nxt_indx = 24; cmt_brch = 1; cmt_brch_indx = 20;
        #1 chk("t2_refuse", grp_ack, 0);
        cyc();
        cmt_brch = 0;
        #1 chk("t2_accept", grp_ack, 1);
        cyc();
        grp_vld = 0;
        #1 chk("t2_free0", free_cnt, 0);

        // mispredict on 62 with rob_head 58; v=1 also commits 60 during FLUSH
        for (int v = 0; v < 2; v++) begin
            hard_reset();
            rob_head = 58;
            grp_vld = 1; grp_br = 4'b0101; nxt_indx = 60; curr_pos = 20; pr_need_inst = 4'b1111;
            cyc();
            grp_br = 4'b0001; nxt_indx = 1; curr_pos = 30;
            cyc();
            grp_vld = 0; mis_pred = 1; brch_mis_indx = 62;
            #1;
            chk("t3_mack", mis_ack, 1);
            chk("t3_merr", mis_err, 0);
            cyc();
            mis_pred = 0;
            if (v == 1) begin cmt_brch = 1; cmt_brch_indx = 60; end
            #1;
            chk("t3_flush", flush, 1);
            chk("t3_fpos", flush_pos, 22);
            cyc();
            cmt_brch = 0; grp_vld = 1; grp_br = 0;
            for (int i = 0; i < 3; i++) begin
                #1 chk("t3_drain_ack", grp_ack, 0);
                cyc();
            end
            grp_vld = 0;
            #1 chk("t3_free", free_cnt, (v == 1) ? 4 : 3);
            cyc();
        end

        // mispredict that matches nothing
        hard_reset();
        mis_pred = 1; brch_mis_indx = 40;
        #1;
        chk("t4_merr", mis_err, 1);
        chk("t4_mack", mis_ack, 1);
        cyc();
        mis_pred = 0;
        #1 chk("t4_noflush", flush, 0);
        cyc();

        // reset during FLUSH (v=0) and during DRAIN (v=1)
        for (int v = 0; v < 2; v++) begin
            hard_reset();
            grp_vld = 1; grp_br = 4'b0001; nxt_indx = 5;
            cyc();
            grp_vld = 0; mis_pred = 1; brch_mis_indx = 5;
            cyc();
            mis_pred = 0;
            if (v == 1) cyc();
            #2;
            hard_reset();
            grp_vld = 1; grp_br = 4'b1111;
            #1 chk("t5_ack_after_rst", grp_ack, 1);
            cyc();
        end

        // random traffic
        hard_reset();
        rp = 0;
        for (int c = 0; c < 3000; c++) begin
            vq.delete();
            for (int i = 0; i < 4; i++) if (m_vld[i]) vq.push_back(m_idx[i]);
            grp_vld      = 1'($urandom_range(0, 1));
            grp_br       = 4'($urandom);
            nxt_indx     = 6'(rp);
            curr_pos     = 6'($urandom);
            pr_need_inst = 4'($urandom);
            rob_head     = 6'(rp - int'($urandom_range(4, 30)));
            cmt_brch     = ($urandom_range(0, 2) == 0);
            if (vq.size() > 0 && $urandom_range(0, 3) != 0)
                cmt_brch_indx = 6'(vq[$urandom_range(0, vq.size() - 1)]);
            else
                cmt_brch_indx = 6'($urandom);
            if (!(mis_pred && !last_mack)) begin
                mis_pred = ($urandom_range(0, 9) == 0);
                if (vq.size() > 0 && $urandom_range(0, 3) != 0)
                    brch_mis_indx = 6'(vq[$urandom_range(0, vq.size() - 1)]);
                else
                    brch_mis_indx = 6'($urandom);
            end
            cyc();
            if (last_ack) rp = (rp + 4) & 63;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
